tsu_queue_reader: RTL and testbench

- Sits directly downstream of the tsu timestamp queue read port, in the q_rd_clk domain.
- Pops one 128-bit timestamp entry per request, manual or automatic, into a holding register.
- Exposes the entry as four 32-bit words for the host register file.
- Provides a registered queue fill level, a wrapping pop counter and sticky error flags.

---
 rtl/tsu_queue_reader.sv | 105 ++++++++++
 tb/tb_tsu_queue_reader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tsu_queue_reader.sv
// Pops timestamp entries from the tsu queue read port into a host-visible hold
// register, with a registered fill level, a wrapping pop counter and sticky error flags.
module tsu_queue_reader #(
  parameter int RD_LAT = 1,  // 1..4
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             q_rd_en,
  input  logic [7:0]       q_rd_stat,
  input  logic [127:0]     q_rd_data,
  input  logic             pop_req,
  input  logic             auto_en,
  input  logic             hold_ack,
  input  logic [1:0]       word_sel,
  output logic [31:0]      word_data,
  output logic             hold_valid,
  output logic [7:0]       level,
  output logic [CNT_W-1:0] pop_cnt,
  output logic             err_underflow,
  output logic             err_busy,
  input  logic             err_clr
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

  // WAIT lasts RD_LAT-1 cycles; the counter is preloaded so that it hits zero
  // in the last WAIT cycle. Unused when RD_LAT==1.
  localparam logic [1:0] WAIT_LD = 2'((RD_LAT > 1) ? RD_LAT - 2 : 0);

  state_t           state, state_nxt;
  logic [1:0]       wait_cnt;
  logic [3:0][31:0] hold;
  logic             trig, busy_evt, unf_evt;

  assign q_rd_en   = (state == ISSUE);
  assign word_data = hold[word_sel];

  always_comb begin
    state_nxt = state;
    busy_evt  = 1'b0;
    unf_evt   = 1'b0;
    trig      = pop_req | (auto_en & ~hold_valid);
    case (state)
      IDLE: begin
        // An unacknowledged entry blocks any pop and outranks the empty check.
        if (pop_req && hold_valid)                        busy_evt  = 1'b1;
        else if (trig && (level != 8'd0) && !hold_valid)  state_nxt = ISSUE;
        else if (pop_req && (level == 8'd0))              unf_evt   = 1'b1;
      end
      ISSUE: begin
        busy_evt  = pop_req;
        state_nxt = (RD_LAT > 1) ? WAIT : CAPTURE;
      end
      WAIT: begin
        busy_evt = pop_req;
        if (wait_cnt == 2'd0) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        busy_evt  = pop_req;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= 2'd0;
    end else begin
      state <= state_nxt;
      if (state == ISSUE)                           wait_cnt <= WAIT_LD;
      else if (state == WAIT && wait_cnt != 2'd0)   wait_cnt <= wait_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold       <= '0;
      hold_valid <= 1'b0;
      pop_cnt    <= '0;
    end else if (state == CAPTURE) begin
      // A same-cycle ack loses to the fresh capture.
      hold       <= q_rd_data;
      hold_valid <= 1'b1;
      pop_cnt    <= pop_cnt + 1'b1;
    end else if (hold_ack) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level         <= 8'd0;
      err_underflow <= 1'b0;
      err_busy      <= 1'b0;
    end else begin
      level         <= q_rd_stat;
      err_underflow <= (err_underflow & ~err_clr) | unf_evt;
      err_busy      <= (err_busy & ~err_clr) | busy_evt;
    end
  end

endmodule

// File: tb/tb_tsu_queue_reader.sv
// Bench for tsu_queue_reader: RD_LAT=1 instance (a) and RD_LAT=3, CNT_W=2 instance (b)
// against queue emulators and an expected-entry model.
module tb_tsu_queue_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic pop_req = 0, auto_en = 0, hold_ack = 0, err_clr = 0;
  logic [1:0] word_sel = 2'd0;
  logic rst_a_n = 0, rst_b_n = 0;

  logic         q_rd_en_a, q_rd_en_b;
  logic [7:0]   q_rd_stat_a = 0, q_rd_stat_b = 0;
  logic [127:0] q_rd_data_a = 0, q_rd_data_b = 0;
  logic [31:0]  word_data_a, word_data_b;
  logic         hold_valid_a, hold_valid_b;
  logic [7:0]   level_a, level_b;
  logic [15:0]  pop_cnt_a;
  logic [1:0]   pop_cnt_b;
  logic         eu_a, eu_b, eb_a, eb_b;

  tsu_queue_reader #(.RD_LAT(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .q_rd_en(q_rd_en_a), .q_rd_stat(q_rd_stat_a),
    .q_rd_data(q_rd_data_a), .pop_req(pop_req), .auto_en(auto_en), .hold_ack(hold_ack),
    .word_sel(word_sel), .word_data(word_data_a), .hold_valid(hold_valid_a),
    .level(level_a), .pop_cnt(pop_cnt_a), .err_underflow(eu_a), .err_busy(eb_a),
    .err_clr(err_clr));

  tsu_queue_reader #(.RD_LAT(3), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .q_rd_en(q_rd_en_b), .q_rd_stat(q_rd_stat_b),
    .q_rd_data(q_rd_data_b), .pop_req(pop_req), .auto_en(auto_en), .hold_ack(hold_ack),
    .word_sel(word_sel), .word_data(word_data_b), .hold_valid(hold_valid_b),
    .level(level_b), .pop_cnt(pop_cnt_b), .err_underflow(eu_b), .err_busy(eb_b),
    .err_clr(err_clr));

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  logic sel = 1'b0;  // which instance the host tasks talk to

  logic [127:0] qa[$], qb[$], expa[$], expb[$];
  int en_a[$], en_b[$];
  logic [128:0] dla [0:4];
  logic [128:0] dlb [0:4];

  logic        cur_hv, cur_en, cur_eu, cur_eb;
  logic [31:0] cur_wd;
  logic [15:0] cur_pc;
  logic [7:0]  cur_lvl;
  assign cur_hv  = sel ? hold_valid_b : hold_valid_a;
  assign cur_en  = sel ? q_rd_en_b : q_rd_en_a;
  assign cur_eu  = sel ? eu_b : eu_a;
  assign cur_eb  = sel ? eb_b : eb_a;
  assign cur_wd  = sel ? word_data_b : word_data_a;
  assign cur_pc  = sel ? {14'd0, pop_cnt_b} : pop_cnt_a;
  assign cur_lvl = sel ? level_b : level_a;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) cyc <= cyc + 1;

  // Queue emulators: pop on the strobe, present the entry exactly RD_LAT cycles
  // later and junk (or a decoy one cycle early) otherwise.
  initial for (int i = 0; i < 5; i++) begin dla[i] = '0; dlb[i] = '0; end

  always @(negedge clk) begin : emu_a
    logic [128:0] dn [0:4];
    for (int k = 4; k > 0; k--) dn[k] = dla[k-1];
    dn[0] = '0;
    if (q_rd_en_a) begin
      chk("a_en_nonempty", 128'(qa.size() != 0), 128'(1));
      chk("a_en_hold_clear", 128'(hold_valid_a), 128'(0));
      en_a.push_back(cyc);
      if (qa.size() != 0) dn[0] = {1'b1, qa.pop_front()};
    end
    q_rd_data_a <= dn[1][128] ? dn[1][127:0] : {$urandom, $urandom, $urandom, $urandom};
    q_rd_stat_a <= 8'(qa.size());
    for (int k = 0; k < 5; k++) dla[k] <= dn[k];
  end

  always @(negedge clk) begin : emu_b
    logic [128:0] dn [0:4];
    for (int k = 4; k > 0; k--) dn[k] = dlb[k-1];
    dn[0] = '0;
    if (q_rd_en_b) begin
      chk("b_en_nonempty", 128'(qb.size() != 0), 128'(1));
      chk("b_en_hold_clear", 128'(hold_valid_b), 128'(0));
      en_b.push_back(cyc);
      if (qb.size() != 0) dn[0] = {1'b1, qb.pop_front()};
    end
    if (dn[3][128])      q_rd_data_b <= dn[3][127:0];
    else if (dn[2][128]) q_rd_data_b <= ~dn[2][127:0];
    else                 q_rd_data_b <= {$urandom, $urandom, $urandom, $urandom};
    q_rd_stat_b <= 8'(qb.size());
    for (int k = 0; k < 5; k++) dlb[k] <= dn[k];
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic int en_cnt();
    return sel ? en_b.size() : en_a.size();
  endfunction

  task automatic push(input int k);
    logic [127:0] e;
    e = {$urandom, $urandom, $urandom, 32'(k)};
    if (sel) begin qb.push_back(e); expb.push_back(e); end
    else     begin qa.push_back(e); expa.push_back(e); end
  endtask

  task automatic check_hold(input string tag, input logic [127:0] e);
    int w0;
    w0 = $urandom_range(0, 3);
    for (int i = 0; i < 4; i++) begin
      word_sel = 2'((w0 + i) % 4);
      #1;
      chk(tag, 128'(cur_wd), 128'(e[32*((w0 + i) % 4) +: 32]));
    end
    word_sel = 2'd0;
  endtask

  task automatic ack();
    hold_ack = 1; tick(); hold_ack = 0;
  endtask

  // Manual pop: strobe one cycle after request, hold valid RD_LAT+1 cycles after strobe.
  task automatic do_pop(output logic [127:0] e);
    int n;
    e = sel ? expb.pop_front() : expa.pop_front();
    pop_req = 1; tick(); pop_req = 0;
    chk("en_after_req", 128'(cur_en), 128'(1));
    tick();
    chk("en_one_cycle", 128'(cur_en), 128'(0));
    n = 1;
    while (!cur_hv && n < 20) begin tick(); n++; end
    chk("hv_latency", 128'(n), 128'(sel ? 4 : 2));
    check_hold("hold_word", e);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin : main
    logic [127:0] e;
    int nen, got;

    tick(2);
    chk("rst_a_en", 128'(q_rd_en_a), 0);   chk("rst_a_hv", 128'(hold_valid_a), 0);
    chk("rst_a_lvl", 128'(level_a), 0);    chk("rst_a_cnt", 128'(pop_cnt_a), 0);
    chk("rst_a_eu", 128'(eu_a), 0);        chk("rst_a_eb", 128'(eb_a), 0);
    chk("rst_a_wd", 128'(word_data_a), 0); chk("rst_b_cnt", 128'(pop_cnt_b), 0);
    chk("rst_b_hv", 128'(hold_valid_b), 0);
    rst_a_n = 1; tick(2);

    // empty queue underflow
    pop_req = 1; tick(); pop_req = 0;
    chk("unf_set", 128'(cur_eu), 1); chk("unf_no_busy", 128'(cur_eb), 0);
    tick(3);
    chk("unf_no_en", 128'(en_cnt()), 0); chk("unf_cnt", 128'(cur_pc), 0);
    err_clr = 1; tick(); err_clr = 0;
    chk("unf_clr", 128'(cur_eu), 0);

    // three manual pops
    for (int k = 0; k < 3; k++) push(k);
    tick(3);
    chk("lvl3", 128'(cur_lvl), 3);
    for (int k = 0; k < 3; k++) begin
      do_pop(e);
      ack();
      chk("ack_clears", 128'(cur_hv), 0);
      chk("ack_keeps_data", 128'(cur_wd), 128'(e[31:0]));
    end
    tick(2);
    chk("cnt3", 128'(cur_pc), 3); chk("en3", 128'(en_cnt()), 3); chk("lvl0", 128'(cur_lvl), 0);

    // busy while holding; outranks underflow since the queue is now empty
    push(7); tick(3);
    do_pop(e);
    nen = en_cnt();
    pop_req = 1; tick(); pop_req = 0;
    chk("busy_set", 128'(cur_eb), 1); chk("busy_no_en", 128'(cur_en), 0);
    chk("busy_no_unf", 128'(cur_eu), 0);
    tick(3);
    chk("busy_en_cnt", 128'(en_cnt()), 128'(nen));
    check_hold("busy_hold", e);
    ack();

    // second request during ISSUE with coincident clear; ack during CAPTURE
    push(8); tick(3);
    e = expa.pop_front();
    nen = en_cnt();
    pop_req = 1; tick();
    chk("issue_en", 128'(cur_en), 1);
    err_clr = 1; tick(); pop_req = 0; err_clr = 0;
    chk("busy_set_wins", 128'(cur_eb), 1);
    hold_ack = 1; tick(); hold_ack = 0;
    chk("capture_beats_ack", 128'(cur_hv), 1);
    check_hold("issue_hold", e);
    tick(3);
    chk("issue_single_en", 128'(en_cnt()), 128'(nen + 1));
    err_clr = 1; tick(); err_clr = 0;
    chk("busy_clr", 128'(cur_eb), 0);
    ack();
    chk("cnt5", 128'(cur_pc), 5);

    // auto mode, immediate acks
    for (int k = 10; k < 15; k++) push(k);
    tick(3);
    nen = en_cnt(); got = 0; word_sel = 2'd0;
    auto_en = 1;
    for (int i = 0; i < 48; i++) begin
      hold_ack = cur_hv;
      if (cur_hv) begin
        e = expa.pop_front();
        chk("auto_word", 128'(cur_wd), 128'(e[31:0]));
        got++;
      end
      tick();
    end
    hold_ack = 0; auto_en = 0;
    chk("auto_got", 128'(got), 5);
    chk("auto_en_cnt", 128'(en_cnt() - nen), 5);
    for (int i = 1; i < 5 && nen + i < en_a.size(); i++)
      chk("auto_spacing", 128'(en_a[nen+i] - en_a[nen+i-1]), 4);
    chk("auto_no_unf", 128'(cur_eu), 0);
    chk("auto_cnt", 128'(cur_pc), 10);
    chk("auto_lvl0", 128'(cur_lvl), 0);

    // RD_LAT=3 instance: reset during WAIT, then counter wrap
    rst_a_n = 0; sel = 1; rst_b_n = 1; tick(2);
    push(20); tick(3);
    e = expb.pop_front();
    pop_req = 1; tick(); pop_req = 0;
    chk("b_en", 128'(cur_en), 1);
    tick();
    rst_b_n = 0; tick();
    chk("rstw_hv", 128'(cur_hv), 0); chk("rstw_cnt", 128'(cur_pc), 0);
    chk("rstw_en", 128'(cur_en), 0);
    rst_b_n = 1; tick(6);
    chk("rstw_no_capture", 128'(cur_hv), 0);
    for (int k = 0; k < 4; k++) begin
      push(30 + k); tick(3);
      do_pop(e);
      chk((k == 3) ? "cnt_wrap" : "b_cnt", 128'(cur_pc), 128'((k + 1) % 4));
      ack();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
